dpram_access_ctrl: RTL and testbench

DPRAM_ACCESS_CTRL -- requirements
Module: dpram_access_ctrl

---
 rtl/dpram_access_ctrl.sv | 165 ++++++++++++++++
 tb/tb_dpram_access_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/dpram_access_ctrl.sv
// Dual-port RAM access controller: valid/ready request handshakes per port, one outstanding
// read per port, and port A priority when both ports hit the same word and either one writes.
module dpram_access_ctrl #(
  parameter  int DEPTH = 8,
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid_a,
  output logic             req_ready_a,
  input  logic             req_we_a,
  input  logic [AW-1:0]    req_addr_a,
  input  logic [WIDTH-1:0] req_wdata_a,
  output logic             rsp_valid_a,
  input  logic             rsp_ready_a,
  output logic [WIDTH-1:0] rsp_rdata_a,
  input  logic             req_valid_b,
  output logic             req_ready_b,
  input  logic             req_we_b,
  input  logic [AW-1:0]    req_addr_b,
  input  logic [WIDTH-1:0] req_wdata_b,
  output logic             rsp_valid_b,
  input  logic             rsp_ready_b,
  output logic [WIDTH-1:0] rsp_rdata_b,
  output logic             ram_we_a,
  output logic [AW-1:0]    ram_addr_a,
  output logic [WIDTH-1:0] ram_wdata_a,
  input  logic [WIDTH-1:0] ram_rdata_a,
  output logic             ram_we_b,
  output logic [AW-1:0]    ram_addr_b,
  output logic [WIDTH-1:0] ram_wdata_b,
  input  logic [WIDTH-1:0] ram_rdata_b,
  output logic [7:0]       coll_cnt
);

  logic             ready_pre_a, ready_pre_b, stall_b, acc_a, acc_b;
  logic             ram_we_a_q, ram_we_a_d, ram_we_b_q, ram_we_b_d;
  logic [AW-1:0]    ram_addr_a_q, ram_addr_a_d, ram_addr_b_q, ram_addr_b_d;
  logic [WIDTH-1:0] ram_wdata_a_q, ram_wdata_a_d, ram_wdata_b_q, ram_wdata_b_d;
  logic             rd1_a_q, rd1_a_d, rd2_a_q, rd2_a_d;
  logic             rd1_b_q, rd1_b_d, rd2_b_q, rd2_b_d;
  logic             rsp_valid_a_q, rsp_valid_a_d, rsp_valid_b_q, rsp_valid_b_d;
  logic [WIDTH-1:0] rsp_rdata_a_q, rsp_rdata_a_d, rsp_rdata_b_q, rsp_rdata_b_d;
  logic [7:0]       coll_cnt_q, coll_cnt_d;

  // Handshake: a port is busy while a read is in the two-stage RAM pipe or a response is unconsumed.
  always_comb begin
    ready_pre_a = !rst && !rd1_a_q && !rd2_a_q && (!rsp_valid_a_q || rsp_ready_a);
    ready_pre_b = !rst && !rd1_b_q && !rd2_b_q && (!rsp_valid_b_q || rsp_ready_b);
    stall_b     = req_valid_a && req_valid_b && (req_addr_a == req_addr_b) &&
                  (req_we_a || req_we_b) && ready_pre_a;
    req_ready_a = ready_pre_a;
    req_ready_b = ready_pre_b && !stall_b;
    acc_a       = req_valid_a && req_ready_a;
    acc_b       = req_valid_b && req_ready_b;
  end

  // Next state for port A: issue to RAM, track the read through RAM latency, hold the response.
  always_comb begin
    ram_we_a_d = acc_a && req_we_a;
    rd1_a_d    = acc_a && !req_we_a;
    rd2_a_d    = rd1_a_q;
    if (acc_a) begin
      ram_addr_a_d  = req_addr_a;
      ram_wdata_a_d = req_wdata_a;
    end else begin
      ram_addr_a_d  = ram_addr_a_q;
      ram_wdata_a_d = ram_wdata_a_q;
    end
    if (rd2_a_q) begin
      rsp_valid_a_d = 1'b1;
      rsp_rdata_a_d = ram_rdata_a;
    end else if (rsp_ready_a) begin
      rsp_valid_a_d = 1'b0;
      rsp_rdata_a_d = rsp_rdata_a_q;
    end else begin
      rsp_valid_a_d = rsp_valid_a_q;
      rsp_rdata_a_d = rsp_rdata_a_q;
    end
  end

  // Next state for port B, identical in shape to port A.
  always_comb begin
    ram_we_b_d = acc_b && req_we_b;
    rd1_b_d    = acc_b && !req_we_b;
    rd2_b_d    = rd1_b_q;
    if (acc_b) begin
      ram_addr_b_d  = req_addr_b;
      ram_wdata_b_d = req_wdata_b;
    end else begin
      ram_addr_b_d  = ram_addr_b_q;
      ram_wdata_b_d = ram_wdata_b_q;
    end
    if (rd2_b_q) begin
      rsp_valid_b_d = 1'b1;
      rsp_rdata_b_d = ram_rdata_b;
    end else if (rsp_ready_b) begin
      rsp_valid_b_d = 1'b0;
      rsp_rdata_b_d = rsp_rdata_b_q;
    end else begin
      rsp_valid_b_d = rsp_valid_b_q;
      rsp_rdata_b_d = rsp_rdata_b_q;
    end
  end

  // Saturating collision-stall counter.
  always_comb begin
    if (stall_b && (coll_cnt_q != 8'hFF)) begin
      coll_cnt_d = coll_cnt_q + 8'd1;
    end else begin
      coll_cnt_d = coll_cnt_q;
    end
  end

  // State registers; reset drops any read still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_we_a_q    <= 1'b0;
      ram_addr_a_q  <= '0;
      ram_wdata_a_q <= '0;
      rd1_a_q       <= 1'b0;
      rd2_a_q       <= 1'b0;
      rsp_valid_a_q <= 1'b0;
      rsp_rdata_a_q <= '0;
      ram_we_b_q    <= 1'b0;
      ram_addr_b_q  <= '0;
      ram_wdata_b_q <= '0;
      rd1_b_q       <= 1'b0;
      rd2_b_q       <= 1'b0;
      rsp_valid_b_q <= 1'b0;
      rsp_rdata_b_q <= '0;
      coll_cnt_q    <= 8'd0;
    end else begin
      ram_we_a_q    <= ram_we_a_d;
      ram_addr_a_q  <= ram_addr_a_d;
      ram_wdata_a_q <= ram_wdata_a_d;
      rd1_a_q       <= rd1_a_d;
      rd2_a_q       <= rd2_a_d;
      rsp_valid_a_q <= rsp_valid_a_d;
      rsp_rdata_a_q <= rsp_rdata_a_d;
      ram_we_b_q    <= ram_we_b_d;
      ram_addr_b_q  <= ram_addr_b_d;
      ram_wdata_b_q <= ram_wdata_b_d;
      rd1_b_q       <= rd1_b_d;
      rd2_b_q       <= rd2_b_d;
      rsp_valid_b_q <= rsp_valid_b_d;
      rsp_rdata_b_q <= rsp_rdata_b_d;
      coll_cnt_q    <= coll_cnt_d;
    end
  end

  assign ram_we_a    = ram_we_a_q;
  assign ram_addr_a  = ram_addr_a_q;
  assign ram_wdata_a = ram_wdata_a_q;
  assign rsp_valid_a = rsp_valid_a_q;
  assign rsp_rdata_a = rsp_rdata_a_q;
  assign ram_we_b    = ram_we_b_q;
  assign ram_addr_b  = ram_addr_b_q;
  assign ram_wdata_b = ram_wdata_b_q;
  assign rsp_valid_b = rsp_valid_b_q;
  assign rsp_rdata_b = rsp_rdata_b_q;
  assign coll_cnt    = coll_cnt_q;

endmodule

// File: tb/tb_dpram_access_ctrl.sv
// Bench for dpram_access_ctrl: behavioural dual-port RAM plus a transaction-level model
// (memory array, read countdowns, response slots) checked every cycle.
module tb_dpram_access_ctrl;
  localparam int DEPTH = 8;
  localparam int WIDTH = 8;
  localparam int AW    = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       v, we, rr;
  logic [AW-1:0]    ad [2];
  logic [WIDTH-1:0] wd [2];
  logic             req_ready_a, req_ready_b, rsp_valid_a, rsp_valid_b;
  logic [WIDTH-1:0] rsp_rdata_a, rsp_rdata_b;
  logic             ram_we_a, ram_we_b;
  logic [AW-1:0]    ram_addr_a, ram_addr_b;
  logic [WIDTH-1:0] ram_wdata_a, ram_wdata_b, ram_rdata_a, ram_rdata_b;
  logic [7:0]       coll_cnt;

  int checks = 0;
  int failures = 0;

  dpram_access_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid_a(v[0]), .req_ready_a(req_ready_a), .req_we_a(we[0]), .req_addr_a(ad[0]),
    .req_wdata_a(wd[0]), .rsp_valid_a(rsp_valid_a), .rsp_ready_a(rr[0]), .rsp_rdata_a(rsp_rdata_a),
    .req_valid_b(v[1]), .req_ready_b(req_ready_b), .req_we_b(we[1]), .req_addr_b(ad[1]),
    .req_wdata_b(wd[1]), .rsp_valid_b(rsp_valid_b), .rsp_ready_b(rr[1]), .rsp_rdata_b(rsp_rdata_b),
    .ram_we_a(ram_we_a), .ram_addr_a(ram_addr_a), .ram_wdata_a(ram_wdata_a), .ram_rdata_a(ram_rdata_a),
    .ram_we_b(ram_we_b), .ram_addr_b(ram_addr_b), .ram_wdata_b(ram_wdata_b), .ram_rdata_b(ram_rdata_b),
    .coll_cnt(coll_cnt)
  );

  always #5 clk = ~clk;

  // Registered, read-first dual-port RAM
  logic [WIDTH-1:0] ram_mem [DEPTH];
  logic             ram_clr;
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < DEPTH; i++) ram_mem[i] <= 8'h00;
    end else begin
      if (ram_we_a) ram_mem[ram_addr_a] <= ram_wdata_a;
      if (ram_we_b) ram_mem[ram_addr_b] <= ram_wdata_b;
    end
    ram_rdata_a <= ram_mem[ram_addr_a];
    ram_rdata_b <= ram_mem[ram_addr_b];
  end

  // Reference model state (index 0 = port A, 1 = port B)
  logic [WIDTH-1:0] m_mem [DEPTH];
  int               m_cnt [2];
  logic             m_rv [2];
  logic [WIDTH-1:0] m_rd [2];
  logic [WIDTH-1:0] m_pd [2];
  logic             m_we [2];
  logic [AW-1:0]    m_addr [2];
  logic [WIDTH-1:0] m_wdata [2];
  int               m_coll;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < 2; p++) begin
      m_cnt[p] = 0; m_rv[p] = 1'b0; m_rd[p] = 8'h00; m_pd[p] = 8'h00;
      m_we[p] = 1'b0; m_addr[p] = 3'd0; m_wdata[p] = 8'h00;
    end
    m_coll = 0;
  endtask

  task automatic drive(input int p, input logic val, input logic w, input logic [AW-1:0] a,
                       input logic [WIDTH-1:0] d);
    v[p] = val; we[p] = w; ad[p] = a; wd[p] = d;
  endtask

  task automatic idle();
    drive(0, 1'b0, 1'b0, 3'd0, 8'h00);
    drive(1, 1'b0, 1'b0, 3'd0, 8'h00);
  endtask

  // One cycle: compare DUT against the model for the current inputs, then advance the model
  // across the coming rising edge. Called and returning on a falling edge.
  task automatic step();
    logic [1:0]       pre, rdy, acc;
    logic             stall;
    logic [WIDTH-1:0] rval [2];
    #1;
    for (int p = 0; p < 2; p++)
      pre[p] = !rst && (m_cnt[p] == 0) && (!m_rv[p] || rr[p]);
    stall  = v[0] && v[1] && (ad[0] == ad[1]) && (we[0] || we[1]) && pre[0];
    rdy[0] = pre[0];
    rdy[1] = pre[1] && !stall;
    check("req_ready_a", {31'd0, req_ready_a}, {31'd0, rdy[0]});
    check("req_ready_b", {31'd0, req_ready_b}, {31'd0, rdy[1]});
    check("rsp_valid_a", {31'd0, rsp_valid_a}, {31'd0, m_rv[0]});
    check("rsp_valid_b", {31'd0, rsp_valid_b}, {31'd0, m_rv[1]});
    check("rsp_rdata_a", {24'd0, rsp_rdata_a}, {24'd0, m_rd[0]});
    check("rsp_rdata_b", {24'd0, rsp_rdata_b}, {24'd0, m_rd[1]});
    check("ram_we_a", {31'd0, ram_we_a}, {31'd0, m_we[0]});
    check("ram_we_b", {31'd0, ram_we_b}, {31'd0, m_we[1]});
    check("ram_addr_a", {29'd0, ram_addr_a}, {29'd0, m_addr[0]});
    check("ram_addr_b", {29'd0, ram_addr_b}, {29'd0, m_addr[1]});
    check("ram_wdata_a", {24'd0, ram_wdata_a}, {24'd0, m_wdata[0]});
    check("ram_wdata_b", {24'd0, ram_wdata_b}, {24'd0, m_wdata[1]});
    check("coll_cnt", {24'd0, coll_cnt}, m_coll);
    acc = v & rdy;
    if (rst) begin
      model_reset();
    end else begin
      for (int p = 0; p < 2; p++) rval[p] = m_mem[ad[p]];
      for (int p = 0; p < 2; p++) begin
        if (m_cnt[p] == 1) begin
          m_rv[p] = 1'b1;
          m_rd[p] = m_pd[p];
        end else if (rr[p]) begin
          m_rv[p] = 1'b0;
        end
        if (m_cnt[p] > 0) m_cnt[p] = m_cnt[p] - 1;
        m_we[p] = acc[p] && we[p];
        if (acc[p]) begin
          m_addr[p]  = ad[p];
          m_wdata[p] = wd[p];
          if (we[p]) m_mem[ad[p]] = wd[p];
          else begin
            m_cnt[p] = 2;
            m_pd[p]  = rval[p];
          end
        end
      end
      if (stall && m_coll < 255) m_coll++;
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; ram_clr = 1'b1; rr = 2'b11;
    idle();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;
    model_reset();
    repeat (3) @(negedge clk);
    ram_clr = 1'b0;
    step();
    rst = 1'b0;

    // Write then read on port A
    drive(0, 1'b1, 1'b1, 3'd3, 8'h5A); step();
    idle(); step();
    drive(0, 1'b1, 1'b0, 3'd3, 8'h00); step();
    idle(); step(); step();
    check("d_raw_valid", {31'd0, rsp_valid_a}, 32'd1);
    check("d_raw_data", {24'd0, rsp_rdata_a}, 32'h5A);
    step();

    // Write/write collision: A wins, B retries
    drive(0, 1'b1, 1'b1, 3'd5, 8'h11); drive(1, 1'b1, 1'b1, 3'd5, 8'h22);
    #1 check("d_coll_ready_b", {31'd0, req_ready_b}, 32'd0);
    step();
    drive(0, 1'b0, 1'b0, 3'd0, 8'h00);
    #1 check("d_coll_retry_b", {31'd0, req_ready_b}, 32'd1);
    step();
    idle(); step();
    drive(0, 1'b1, 1'b0, 3'd5, 8'h00); step();
    idle(); step(); step();
    check("d_coll_data", {24'd0, rsp_rdata_a}, 32'h22);
    check("d_coll_cnt", {24'd0, coll_cnt}, 32'd1);
    step();

    // Read/read same address is not a collision
    rst = 1'b1; step(); rst = 1'b0;
    drive(0, 1'b1, 1'b1, 3'd2, 8'h7E); step();
    idle(); step();
    drive(0, 1'b1, 1'b0, 3'd2, 8'h00); drive(1, 1'b1, 1'b0, 3'd2, 8'h00); step();
    idle(); step(); step();
    check("d_rr_data_a", {24'd0, rsp_rdata_a}, 32'h7E);
    check("d_rr_data_b", {24'd0, rsp_rdata_b}, 32'h7E);
    check("d_rr_coll", {24'd0, coll_cnt}, 32'd0);
    step();

    // Response back-pressure on port B
    drive(1, 1'b1, 1'b0, 3'd2, 8'h00); step();
    idle(); rr[1] = 1'b0; step(); step();
    drive(1, 1'b1, 1'b0, 3'd3, 8'h00);
    repeat (4) step();
    check("d_bp_data", {24'd0, rsp_rdata_b}, 32'h7E);
    rr[1] = 1'b1; step(); step();
    idle(); repeat (3) step();

    // Reset one cycle after a read is accepted
    drive(0, 1'b1, 1'b0, 3'd3, 8'h00); step();
    idle(); rst = 1'b1; step(); rst = 1'b0;
    repeat (4) step();
    check("d_rst_no_rsp", {31'd0, rsp_valid_a}, 32'd0);

    // Sustained collisions saturate the counter
    drive(0, 1'b1, 1'b1, 3'd1, 8'h33); drive(1, 1'b1, 1'b1, 3'd1, 8'h44);
    repeat (300) step();
    check("d_sat_cnt", {24'd0, coll_cnt}, 32'd255);
    repeat (5) step();
    check("d_sat_hold", {24'd0, coll_cnt}, 32'd255);
    idle(); step();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      for (int p = 0; p < 2; p++) begin
        drive(p, ($urandom_range(0, 9) < 6), $urandom_range(0, 1) == 1,
              3'($urandom_range(0, 3)), 8'($urandom));
        rr[p] = ($urandom_range(0, 3) != 0);
      end
      rst = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 1'b0; idle(); rr = 2'b11;
    repeat (4) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
